// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - audio PLL reset sequencing, lock qualification and retry/fault supervision
// Runs on the free-running codec MCLK so it keeps working while the PLL is unlocked.
module pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 122880,
  parameter int LOCK_STABLE_CYCLES  = 4096,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 17,
  parameter int RETRY_W             = 2
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               clear_fault,
  output logic               pll_rst,
  output logic               fabric_rst,
  output logic               clk_ok,
  output logic               fault,
  output logic               lol_pulse,
  output logic [RETRY_W-1:0] retry_count
);

  localparam logic [2:0] S_RESET_PLL = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABILIZE = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_FAULT     = 3'd4;

  localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TMO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STAB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0]   stab_q, stab_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               lol_q, lol_d;
  logic [1:0]         sync_q;
  logic               locked_s;
  logic               run_hit;
  logic               timeout_hit;
  logic [RETRY_W-1:0] retry_inc;

  assign locked_s  = sync_q[1];
  assign retry_inc = retry_q + RETRY_W'(1);

  // Stable window wins over a coincident timeout.
  assign run_hit     = (state_q == S_STABILIZE) && locked_s && (stab_q == STAB_LAST);
  assign timeout_hit = ((state_q == S_WAIT_LOCK) || (state_q == S_STABILIZE))
                       && (tmo_q == TMO_LAST) && !run_hit;

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    stab_d  = stab_q;
    retry_d = retry_q;
    lol_d   = 1'b0;
    if (timeout_hit) begin
      retry_d = retry_inc;
      tmo_d   = '0;
      stab_d  = '0;
      state_d = (retry_inc == RETRY_MAX) ? S_FAULT : S_RESET_PLL;
    end else begin
      case (state_q)
        S_RESET_PLL: begin
          if (tmo_q == RST_LAST) begin
            state_d = S_WAIT_LOCK;
            tmo_d   = '0;
          end else begin
            tmo_d = tmo_q + CNT_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          tmo_d = tmo_q + CNT_W'(1);
          if (locked_s) begin
            state_d = S_STABILIZE;
            stab_d  = '0;
          end
        end
        S_STABILIZE: begin
          if (run_hit) begin
            state_d = S_RUN;
            tmo_d   = '0;
            stab_d  = '0;
            retry_d = '0;
          end else if (!locked_s) begin
            // tmo keeps running so a chattering lock cannot extend the timeout
            state_d = S_WAIT_LOCK;
            stab_d  = '0;
            tmo_d   = tmo_q + CNT_W'(1);
          end else begin
            stab_d = stab_q + CNT_W'(1);
            tmo_d  = tmo_q + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (!locked_s) begin
            state_d = S_RESET_PLL;
            tmo_d   = '0;
            lol_d   = 1'b1;
          end
        end
        S_FAULT: begin
          if (clear_fault) begin
            state_d = S_RESET_PLL;
            retry_d = '0;
            tmo_d   = '0;
            stab_d  = '0;
          end
        end
        default: begin
          state_d = S_RESET_PLL;
          tmo_d   = '0;
          stab_d  = '0;
          retry_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q <= S_RESET_PLL;
      tmo_q   <= '0;
      stab_q  <= '0;
      retry_q <= '0;
      lol_q   <= 1'b0;
      sync_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      stab_q  <= stab_d;
      retry_q <= retry_d;
      lol_q   <= lol_d;
      sync_q  <= {sync_q[0], pll_locked};
    end
  end

  assign pll_rst     = (state_q == S_RESET_PLL) || (state_q == S_FAULT);
  assign fabric_rst  = (state_q != S_RUN);
  assign clk_ok      = (state_q == S_RUN);
  assign fault       = (state_q == S_FAULT);
  assign lol_pulse   = lol_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - directed self-checking bench for pll_lock_supervisor
// Small parameters: 4-cycle PLL reset, 64-cycle timeout, 8-cycle stable window, 3 retries.
module tb_pll_lock_supervisor;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       clear_fault = 1'b0;
  logic       pll_rst, fabric_rst, clk_ok, fault, lol_pulse;
  logic [1:0] retry_count;
  int         checks = 0;
  int         errors = 0;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES(4), .LOCK_TIMEOUT_CYCLES(64), .LOCK_STABLE_CYCLES(8),
    .MAX_RETRIES(3), .CNT_W(17), .RETRY_W(2)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .clear_fault(clear_fault),
    .pll_rst(pll_rst), .fabric_rst(fabric_rst), .clk_ok(clk_ok), .fault(fault),
    .lol_pulse(lol_pulse), .retry_count(retry_count)
  );

  always #5 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  // Leaves the bench just after the last reset edge with rst released (t=0).
  task automatic apply_reset(input logic locked);
    rst = 1'b1; pll_locked = locked; clear_fault = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    rst = 1'b1; pll_locked = 1'b0; clear_fault = 1'b0;
    tick(); tick();
    obs = {pll_rst, fabric_rst, clk_ok, fault, lol_pulse, retry_count};
    checks++;
    if (obs !== 7'b1100000) begin
      errors++;
      $display("FAIL reset_outputs got %b want %b", obs, 7'b1100000);
    end
  endtask

  task automatic test_clean_start();
    int n;
    apply_reset(1'b0);
    n = 0;
    do begin tick(); n++; end while (pll_rst === 1'b1 && n < 20);
    checks++;
    if (n != 4) begin errors++; $display("FAIL clean_pll_rst_len got %0d want 4", n); end
    repeat (10) tick();
    pll_locked = 1'b1;
    n = 0;
    while (clk_ok !== 1'b1 && n < 40) begin tick(); n++; end
    checks++;
    if (n != 11) begin errors++; $display("FAIL clean_run_latency got %0d want 11", n); end
    checks++;
    if ({fabric_rst, pll_rst, fault, retry_count} !== 5'b00000) begin
      errors++;
      $display("FAIL clean_run_outputs got %b want 00000", {fabric_rst, pll_rst, fault, retry_count});
    end
  endtask

  task automatic test_never_locks();
    logic [5:0] obs, exp;
    logic [1:0] rc;
    apply_reset(1'b0);
    for (int t = 0; t <= 230; t++) begin
      rc  = (t < 68) ? 2'd0 : (t < 136) ? 2'd1 : (t < 204) ? 2'd2 : 2'd3;
      exp = {(t >= 204) || ((t % 68) < 4), 1'b1, 1'b0, (t >= 204), rc};
      obs = {pll_rst, fabric_rst, clk_ok, fault, retry_count};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL never_locks t=%0d got %b want %b", t, obs, exp);
      end
      tick();
    end
  endtask

  task automatic test_chatter();
    logic saw_run;
    saw_run = 1'b0;
    apply_reset(1'b0);
    for (int t = 0; t <= 68; t++) begin
      if (clk_ok === 1'b1) saw_run = 1'b1;
      if (t == 67) begin
        checks++;
        if ({pll_rst, retry_count} !== 3'b000) begin
          errors++;
          $display("FAIL chatter_pre_timeout got %b want 000", {pll_rst, retry_count});
        end
      end
      if (t == 68) begin
        checks++;
        if ({pll_rst, retry_count} !== 3'b101) begin
          errors++;
          $display("FAIL chatter_timeout got %b want 101", {pll_rst, retry_count});
        end
      end
      if (t >= 4) pll_locked = (((t - 4) / 5) % 2 == 0);
      if (t < 68) tick();
    end
    checks++;
    if (saw_run !== 1'b0) begin errors++; $display("FAIL chatter_no_run got %b want 0", saw_run); end
  endtask

  task automatic test_loss_of_lock();
    int n;
    logic [5:0] obs, exp;
    apply_reset(1'b1);
    n = 0;
    while (clk_ok !== 1'b1 && n < 40) begin tick(); n++; end
    checks++;
    if (n != 13) begin errors++; $display("FAIL lol_initial_run got %0d want 13", n); end
    pll_locked = 1'b0;
    for (int s = 1; s <= 17; s++) begin
      tick();
      if (s == 1) pll_locked = 1'b1;
      exp = {(s == 3), (s >= 3 && s < 16), (s < 3 || s >= 16), (s >= 3 && s <= 6), 2'b00};
      obs = {lol_pulse, fabric_rst, clk_ok, pll_rst, retry_count};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL loss_of_lock s=%0d got %b want %b", s, obs, exp);
      end
    end
  endtask

  task automatic test_fault_recovery();
    int n;
    apply_reset(1'b0);
    n = 0;
    while (fault !== 1'b1 && n < 300) begin tick(); n++; end
    checks++;
    if (n != 204 || retry_count !== 2'd3) begin
      errors++;
      $display("FAIL fault_entry got n=%0d retry=%0d want n=204 retry=3", n, retry_count);
    end
    pll_locked = 1'b1;
    repeat (6) tick();
    checks++;
    if ({fault, pll_rst, fabric_rst} !== 3'b111) begin
      errors++;
      $display("FAIL fault_holds got %b want 111", {fault, pll_rst, fabric_rst});
    end
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    checks++;
    if ({fault, pll_rst, retry_count} !== 4'b0100) begin
      errors++;
      $display("FAIL fault_clear got %b want 0100", {fault, pll_rst, retry_count});
    end
    for (int s = 2; s <= 14; s++) begin
      tick();
      if (s == 4 || s == 5) begin
        checks++;
        if (pll_rst !== (s == 4)) begin
          errors++;
          $display("FAIL recover_pll_rst s=%0d got %b want %b", s, pll_rst, (s == 4));
        end
      end
      if (s == 13 || s == 14) begin
        checks++;
        if (clk_ok !== (s == 14)) begin
          errors++;
          $display("FAIL recover_run s=%0d got %b want %b", s, clk_ok, (s == 14));
        end
      end
    end
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    repeat (3) tick();
    checks++;
    if ({clk_ok, fabric_rst, pll_rst, fault, retry_count} !== 6'b100000) begin
      errors++;
      $display("FAIL clear_in_run got %b want 100000", {clk_ok, fabric_rst, pll_rst, fault, retry_count});
    end
  endtask

  task automatic test_reset_mid_stabilize();
    int n;
    apply_reset(1'b1);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({pll_rst, fabric_rst, clk_ok, fault, lol_pulse, retry_count} !== 7'b1100000) begin
      errors++;
      $display("FAIL mid_reset got %b want 1100000",
               {pll_rst, fabric_rst, clk_ok, fault, lol_pulse, retry_count});
    end
    rst = 1'b0;
    n = 0;
    do begin tick(); n++; end while (pll_rst === 1'b1 && n < 20);
    checks++;
    if (n != 4) begin errors++; $display("FAIL mid_reset_pll_rst got %0d want 4", n); end
    while (clk_ok !== 1'b1 && n < 60) begin tick(); n++; end
    checks++;
    if (n != 13) begin errors++; $display("FAIL mid_reset_run got %0d want 13", n); end
  endtask

  initial begin
    test_reset();
    test_clean_start();
    test_never_locks();
    test_chatter();
    test_loss_of_lock();
    test_fault_recovery();
    test_reset_mid_stabilize();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
